// File: rtl/down_counter_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_counter_pkg
// Shared definitions for the down_counter_timer slice: default parameter
// values and the FSM state encodings (IDLE/RUN/DONE) used by the top level.
// -----------------------------------------------------------------------------
package down_counter_pkg;

    // Default counter/load width and prescale ratio
    localparam int unsigned DEFAULT_WIDTH    = 32'd4;
    localparam int unsigned DEFAULT_PRESCALE = 32'd1;

    // State encodings; busy/done are decoded directly from these
    localparam logic [1:0] IDLE_CODE = 2'b00;
    localparam logic [1:0] RUN_CODE  = 2'b01;
    localparam logic [1:0] DONE_CODE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = IDLE_CODE,
        RUN  = RUN_CODE,
        DONE = DONE_CODE
    } state_e;

endpackage

// File: rtl/down_counter_timer_if.sv
// -----------------------------------------------------------------------------
// down_counter_timer_if
// Control/status bundle of the down_counter_timer.
//   load        : synchronous load strobe            (master -> slave)
//   load_val    : start/reload value                 (master -> slave)
//   en          : count enable                       (master -> slave)
//   auto_reload : 1 = periodic, 0 = one-shot         (master -> slave)
//   q           : current count                      (slave -> master)
//   tc          : 1-cycle terminal-count pulse       (slave -> master)
//   busy / done : state RUN / state DONE             (slave -> master)
// -----------------------------------------------------------------------------
interface down_counter_timer_if
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, en, auto_reload,
        input  q, tc, busy, done
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output q, tc, busy, done
    );
endinterface

// File: rtl/down_counter_timer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the count enable by PRESCALE: tick is high for one enabled cycle out
// of every PRESCALE enabled cycles. The phase only advances while en=1, so a
// pause keeps any partial prescale.
//   clk     : clock
//   clear_n : asynchronous active-low clear
//   en      : count enable
//   srst    : synchronous clear of the phase (driven by the load strobe)
//   tick    : count tick
// With PRESCALE=1 the block is a pass-through of en.
// -----------------------------------------------------------------------------
module tick_prescaler
    import down_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic clear_n,
    input  logic en,
    input  logic srst,
    output logic tick
);

    generate
        if (PRESCALE <= 32'd1) begin : g_pass
            // No phase state is needed; clock/reset inputs are intentionally idle
            logic unused_s;
            assign unused_s = clk ^ clear_n ^ srst;
            assign tick     = en;
        end else begin : g_div
            localparam int unsigned CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST_PHASE = CW'(PRESCALE - 32'd1);
            localparam logic [CW-1:0] ZERO_PHASE = {CW{1'b0}};
            localparam logic [CW-1:0] ONE_PHASE  = CW'(32'd1);

            logic [CW-1:0] phase_r;

            // Phase counter 0..PRESCALE-1, advancing only on enabled cycles
            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n) begin
                    phase_r <= ZERO_PHASE;
                end else if (srst) begin
                    phase_r <= ZERO_PHASE;
                end else if (en) begin
                    if (phase_r == LAST_PHASE) begin
                        phase_r <= ZERO_PHASE;
                    end else begin
                        phase_r <= phase_r + ONE_PHASE;
                    end
                end else begin
                    phase_r <= phase_r;
                end
            end

            assign tick = en & (phase_r == LAST_PHASE);
        end
    endgenerate

endmodule

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
// Loadable down-counter with a registered 1-cycle terminal-count pulse,
// one-shot / auto-reload modes and a clock-enable prescaler.
//   clk     : clock, all state changes on the rising edge
//   clear_n : asynchronous active-low clear of all state and outputs
//   bus     : slave side of down_counter_timer_if
//             (load, load_val, en, auto_reload in; q, tc, busy, done out)
// A non-zero load starts a run of load_val ticks; a zero load parks the
// counter in IDLE. In RUN the count steps down on each tick; at 1 it either
// reloads from rld (periodic) or goes to 0 and DONE (one-shot), pulsing tc.
// -----------------------------------------------------------------------------
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                  clk,
    input  logic                  clear_n,
    down_counter_timer_if.slave   bus
);

    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);

    state_e           state_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rld_r;
    logic             tc_r;
    logic             tick_s;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (bus.en),
        .srst    (bus.load),
        .tick    (tick_s)
    );

    // FSM, count/reload datapath and terminal-count register
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r <= IDLE;
            q_r     <= ZERO_VAL;
            rld_r   <= ZERO_VAL;
            tc_r    <= 1'b0;
        end else begin
            // tc is a single-cycle pulse unless a terminal tick re-raises it
            tc_r <= 1'b0;
            if (bus.load) begin
                // Load wins over a coincident tick; tc stays low
                if (bus.load_val != ZERO_VAL) begin
                    q_r     <= bus.load_val;
                    rld_r   <= bus.load_val;
                    state_r <= RUN;
                end else begin
                    q_r     <= ZERO_VAL;
                    state_r <= IDLE;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        q_r <= q_r;
                    end
                    RUN: begin
                        if (tick_s) begin
                            if (q_r > ONE_VAL) begin
                                q_r <= q_r - ONE_VAL;
                            end else if (bus.auto_reload) begin
                                // Reload straight from 1, so 0 is never shown
                                q_r  <= rld_r;
                                tc_r <= 1'b1;
                            end else begin
                                q_r     <= ZERO_VAL;
                                tc_r    <= 1'b1;
                                state_r <= DONE;
                            end
                        end else begin
                            q_r <= q_r;
                        end
                    end
                    DONE: begin
                        q_r <= ZERO_VAL;
                    end
                    default: begin
                        // Unreachable encoding: fall back to a safe parked state
                        q_r     <= ZERO_VAL;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.tc   = tc_r;
    assign bus.busy = (state_r == RUN);
    assign bus.done = (state_r == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: two instances (PRESCALE=1 and 4) share
// the same stimulus; a tick-counting model checks both every cycle and
// hand-computed literal checks pin the expected sequences.
module tb_down_counter_timer;

    logic       clk;
    logic       clear_n;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       ar;

    int n_vec = 0;
    int n_err = 0;

    down_counter_timer_if #(.WIDTH(4)) if1 ();
    down_counter_timer_if #(.WIDTH(4)) if4 ();

    assign if1.load = load;  assign if1.load_val = load_val;
    assign if1.en   = en;    assign if1.auto_reload = ar;
    assign if4.load = load;  assign if4.load_val = load_val;
    assign if4.en   = en;    assign if4.auto_reload = ar;

    down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk (clk), .clear_n (clear_n), .bus (if1)
    );
    down_counter_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (
        .clk (clk), .clear_n (clear_n), .bus (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- model: count enabled cycles since the run began ----------
    localparam int PV [2] = '{1, 4};
    int m_n   [2];   // period N (load value)
    int m_e   [2];   // enabled cycles since load / last reload
    int m_q   [2];
    bit m_run [2];
    bit m_done[2];
    bit m_tc  [2];

    task automatic model_step(input int d, input bit rn, input bit ld,
                              input int lv, input bit e, input bit a);
        int ticks;
        m_tc[d] = 1'b0;
        if (!rn) begin
            m_n[d] = 0; m_e[d] = 0; m_q[d] = 0; m_run[d] = 1'b0; m_done[d] = 1'b0;
        end else if (ld) begin
            m_e[d] = 0; m_done[d] = 1'b0;
            if (lv != 0) begin
                m_n[d] = lv; m_q[d] = lv; m_run[d] = 1'b1;
            end else begin
                m_q[d] = 0; m_run[d] = 1'b0;
            end
        end else if (m_run[d] && e) begin
            m_e[d]++;
            if (m_e[d] % PV[d] == 0) begin
                ticks = m_e[d] / PV[d];
                if (ticks >= m_n[d]) begin
                    m_tc[d] = 1'b1;
                    if (a) begin
                        m_e[d] = 0; m_q[d] = m_n[d];
                    end else begin
                        m_q[d] = 0; m_run[d] = 1'b0; m_done[d] = 1'b1;
                    end
                end else begin
                    m_q[d] = m_n[d] - ticks;
                end
            end
        end
    endtask

    // Compare process: sample inputs at the edge, check outputs 1 time unit later
    initial begin
        bit s_rn, s_ld, s_e, s_a;
        int s_lv;
        for (int d = 0; d < 2; d++) model_step(d, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        forever begin
            @(posedge clk);
            s_rn = clear_n; s_ld = load; s_lv = int'(load_val); s_e = en; s_a = ar;
            #1;
            for (int d = 0; d < 2; d++) model_step(d, s_rn, s_ld, s_lv, s_e, s_a);
            chk("m1.q",    {28'd0, if1.q},    m_q[0]);
            chk("m1.tc",   {31'd0, if1.tc},   {31'd0, m_tc[0]});
            chk("m1.busy", {31'd0, if1.busy}, {31'd0, m_run[0]});
            chk("m1.done", {31'd0, if1.done}, {31'd0, m_done[0]});
            chk("m4.q",    {28'd0, if4.q},    m_q[1]);
            chk("m4.tc",   {31'd0, if4.tc},   {31'd0, m_tc[1]});
            chk("m4.busy", {31'd0, if4.busy}, {31'd0, m_run[1]});
            chk("m4.done", {31'd0, if4.done}, {31'd0, m_done[1]});
        end
    end

    // ---------------- directed stimulus with literal expectations ---------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] v, input logic a);
        load = 1'b1; load_val = v; ar = a;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; ar = 1'b0;
        cyc(3);
        chk("rst.q", {28'd0, if1.q}, 32'd0);
        chk("rst.busy", {31'd0, if1.busy}, 32'd0);
        chk("rst.done", {31'd0, if1.done}, 32'd0);
        chk("rst.tc", {31'd0, if1.tc}, 32'd0);
        clear_n = 1'b1;
        cyc(2);

        // One-shot, load 5: 5,4,3,2,1,0 with tc on q=0, then DONE holds 0
        en = 1'b1;
        do_load(4'd5, 1'b0);
        chk("os.q0", {28'd0, if1.q}, 32'd5);
        chk("os.busy", {31'd0, if1.busy}, 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            chk("os.q", {28'd0, if1.q}, 32'(5 - i));
            chk("os.tc", {31'd0, if1.tc}, (i == 5) ? 32'd1 : 32'd0);
        end
        chk("os.done", {31'd0, if1.done}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("os.hold.q", {28'd0, if1.q}, 32'd0);
            chk("os.hold.tc", {31'd0, if1.tc}, 32'd0);
        end

        // Auto-reload, load 3: 3,2,1,3,2,1,3 with tc on each reload
        do_load(4'd3, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("ar.q", {28'd0, if1.q}, 32'(3 - (i % 3)));
            chk("ar.tc", {31'd0, if1.tc}, (i > 0 && i % 3 == 0) ? 32'd1 : 32'd0);
            chk("ar.busy", {31'd0, if1.busy}, 32'd1);
            cyc(1);
        end

        // Pause: load 6, freeze at 4 for 4 cycles, tc 4 cycles late
        do_load(4'd6, 1'b0);
        cyc(2);
        chk("pz.q4", {28'd0, if1.q}, 32'd4);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("pz.hold", {28'd0, if1.q}, 32'd4);
        end
        en = 1'b1;
        cyc(1); chk("pz.q3", {28'd0, if1.q}, 32'd3);
        cyc(2); chk("pz.tc_early", {31'd0, if1.tc}, 32'd0);
        cyc(1); chk("pz.tc", {31'd0, if1.tc}, 32'd1);
        chk("pz.q0", {28'd0, if1.q}, 32'd0);

        // Reload mid-count: load 9, at q=5 load 2
        do_load(4'd9, 1'b0);
        cyc(4);
        chk("mid.q5", {28'd0, if1.q}, 32'd5);
        do_load(4'd2, 1'b0);
        chk("mid.q2", {28'd0, if1.q}, 32'd2);
        chk("mid.notc", {31'd0, if1.tc}, 32'd0);
        cyc(1); chk("mid.q1", {28'd0, if1.q}, 32'd1);
        cyc(1); chk("mid.tc", {31'd0, if1.tc}, 32'd1);

        // PRESCALE=4, load 2: q steps every 4 cycles, tc 8 cycles after load
        do_load(4'd2, 1'b0);
        chk("ps.q0", {28'd0, if4.q}, 32'd2);
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk("ps.q", {28'd0, if4.q}, (i < 4) ? 32'd2 : (i < 8) ? 32'd1 : 32'd0);
            chk("ps.tc", {31'd0, if4.tc}, (i == 8) ? 32'd1 : 32'd0);
        end
        // Load of 0 parks in IDLE with no tc
        do_load(4'd0, 1'b0);
        chk("z.q", {28'd0, if4.q}, 32'd0);
        chk("z.busy", {31'd0, if4.busy}, 32'd0);
        chk("z.done", {31'd0, if4.done}, 32'd0);
        chk("z.tc", {31'd0, if4.tc}, 32'd0);

        // Async clear between edges while q=7 in RUN
        do_load(4'd7, 1'b1);
        chk("ac.q7", {28'd0, if1.q}, 32'd7);
        #2 clear_n = 1'b0;
        #1;
        chk("ac.q", {28'd0, if1.q}, 32'd0);
        chk("ac.busy", {31'd0, if1.busy}, 32'd0);
        chk("ac.tc", {31'd0, if1.tc}, 32'd0);
        chk("ac.busy4", {31'd0, if4.busy}, 32'd0);
        cyc(1);
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("ac.idle.q", {28'd0, if1.q}, 32'd0);
            chk("ac.idle.busy", {31'd0, if1.busy}, 32'd0);
        end
        do_load(4'd3, 1'b0);
        chk("ac.resume", {28'd0, if1.q}, 32'd3);
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
